fp_addsub_gen: RTL and testbench
================================

FP_ADDSUB_GEN -- requirements
Module: fp_addsub_gen

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width (range 4..11).
REQ-002 SHALL have parameter MAN_W, default 23, stored fraction width (range 4..52); word width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port in_valid  input  1  operand pair valid.
REQ-006 SHALL have port in_ready  output  1  block can accept operands.
REQ-007 SHALL have port op_sub  input  1  1 = a-b, 0 = a+b; sampled with operands.
REQ-008 SHALL have ports in_a, in_b  input  W  IEEE-style operands.
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts result.
REQ-011 SHALL have port out_z  output  W  result.
REQ-012 SHALL have ports overflow, underflow, invalid, inexact  output  1 each  exception flags, valid with out_valid.

Function
REQ-013 SHALL accept operands on an edge where in_valid && in_ready; in_ready = 1 only in state IDLE.
REQ-014 SHALL sequence IDLE -> UNPACK -> ALIGN -> ADD -> NORM -> ROUND -> OUT -> IDLE; special operands go UNPACK -> OUT.
REQ-015 SHALL assert out_valid 6 cycles after the accepting edge for normal operands and 2 cycles after it for special operands.
REQ-016 SHALL hold out_z and flags stable in OUT until out_valid && out_ready, then return to IDLE; a new accept needs at least one IDLE cycle.
REQ-017 SHALL, in UNPACK, insert the hidden 1 for nonzero exponent and append guard, round and sticky bits; effective b sign = b sign XOR op_sub.
REQ-018 SHALL, in ALIGN, right-shift the smaller-exponent mantissa by the exponent difference in one cycle, OR-ing shifted-out bits into sticky; shift saturates at MAN_W+3.
REQ-019 SHALL, in ADD, add for equal effective signs, else subtract the smaller magnitude from the larger; result sign = sign of larger operand.
REQ-020 SHALL, in NORM, handle carry-out with a 1-bit right shift (exponent+1), else left-shift by leading-zero count in one cycle, clamped at minimum exponent.
REQ-021 SHALL round to nearest, ties to even; a rounding carry renormalises and increments the exponent.
REQ-022 SHALL return NaN (sign 0, exponent all 1, fraction MSB 1, rest 0) with invalid=1 for any NaN input or inf-inf of opposite effective sign.
REQ-023 SHALL return correctly signed infinity for one infinite operand or two same-signed infinities, flags 0.
REQ-024 SHALL return +0 for exact cancellation, and -0 only when both effective operands are -0.
REQ-025 SHALL return infinity with overflow=1 and inexact=1 when the rounded exponent reaches all-ones.
REQ-026 SHALL set inexact=1 whenever guard|round|sticky was nonzero before rounding.

Reset
REQ-027 SHALL, on rst, enter IDLE and drive out_valid=0, out_z=0, all flags 0, in_ready=1 on the next cycle.
REQ-028 SHALL, on rst mid-operation, abandon the operation; no out_valid for it.
REQ-029 SHALL give rst priority over any simultaneous handshake.

Configuration
REQ-030 SHALL, with FP_ADDSUB_SUBNORMAL_EN defined, treat zero-exponent inputs as subnormal (exponent 1, no hidden bit) and produce gradual-underflow results; underflow=1 only when the result is tiny and inexact.
REQ-031 SHALL, without FP_ADDSUB_SUBNORMAL_EN, flush subnormal inputs to signed zero and flush tiny results to signed zero with underflow=1, inexact=1.

Verification (EXP_W=8, MAN_W=23)
REQ-032 SHALL cover: a=0x3F800000, b=0x40000000, op_sub=0 -> out_z=0x40400000, flags 0, out_valid 6 cycles after accept.
REQ-033 SHALL cover: a=b=0x3F800000, op_sub=1 -> out_z=0x00000000, flags 0.
REQ-034 SHALL cover: a=b=0x7F7FFFFF, op_sub=0 -> out_z=0x7F800000, overflow=1, inexact=1.
REQ-035 SHALL cover: a=b=0x7F800000, op_sub=1 -> out_z=0x7FC00000, invalid=1, out_valid 2 cycles after accept.
REQ-036 SHALL cover: a=b=0x00000001, op_sub=0 -> 0x00000002 with macro; 0x00000000, underflow=1 without.
REQ-037 SHALL cover: out_ready low 5 cycles -> out_z held, in_ready=0; rst pulse in ALIGN -> no out_valid, in_ready=1 next cycle.

Source files
------------

// File: rtl/fp_addsub_gen.sv
// Multi-cycle floating-point adder/subtractor: unpack, align, add, normalise, round, hold result.
// Define FP_ADDSUB_SUBNORMAL_EN for gradual underflow; otherwise subnormals flush to zero.
module fp_addsub_gen #(
  parameter int unsigned EXP_W = 8,
  parameter int unsigned MAN_W = 23
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       op_sub,
  input  logic [EXP_W+MAN_W:0]       in_a,
  input  logic [EXP_W+MAN_W:0]       in_b,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [EXP_W+MAN_W:0]       out_z,
  output logic                       overflow,
  output logic                       underflow,
  output logic                       invalid,
  output logic                       inexact
);
  localparam int unsigned W  = 1 + EXP_W + MAN_W;
  localparam int unsigned MW = MAN_W + 4;   // hidden + fraction + guard/round/sticky
  localparam int unsigned XW = EXP_W + 1;   // exponent with headroom for overflow detection
  localparam int unsigned DW = EXP_W + 7;   // wide enough to compare against MW

  typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, OUT} state_t;
  state_t state, state_next;

  logic [W-1:0]  a_q, b_q;
  logic          sub_q, sa_q, sb_q, zsign_q, zero_q, ftz_q;
  logic [XW-1:0] ea_q, eb_q;
  logic [MW-1:0] ma_q, mb_q;
  logic [MW:0]   sum_q;

  // Returns {flushed_nonzero, exponent, mantissa with GRS}.
  function automatic logic [XW+MW:0] unpack(input logic [W-1:0] x);
    logic [EXP_W-1:0] e;
    logic [MAN_W-1:0] f;
    e = x[W-2:MAN_W];
    f = x[MAN_W-1:0];
    if (e != '0) unpack = {1'b0, XW'(e), 1'b1, f, 3'b000};
`ifdef FP_ADDSUB_SUBNORMAL_EN
    else unpack = {1'b0, XW'(1), 1'b0, f, 3'b000};
`else
    else unpack = {|f, XW'(1), MW'(0)};
`endif
  endfunction

  logic [XW+MW:0] ua, ub;
  logic           sbe, a_nan, b_nan, a_inf, b_inf, special;
  logic [W-1:0]   z_sp, z_rnd, z_next;
  logic [3:0]     fl_sp, fl_rnd, fl_next;   // {overflow, underflow, invalid, inexact}
  logic           a_big, big_s, sml_s;
  logic [XW-1:0]  big_e, sml_e, norm_e, re;
  logic [MW-1:0]  big_m, sml_m, sml_al, norm_m;
  logic [DW-1:0]  diff, ash, lz, limit, nsh;
  logic [MW:0]    sum;
  logic [MAN_W+1:0] rnd;
  logic [MAN_W:0] rm;
  logic           inx, load_out;

  // Datapath combinational logic for every stage.
  always_comb begin
    ua = unpack(a_q);
    ub = unpack(b_q);
    sbe   = b_q[W-1] ^ sub_q;
    a_nan = (&a_q[W-2:MAN_W]) && (|a_q[MAN_W-1:0]);
    b_nan = (&b_q[W-2:MAN_W]) && (|b_q[MAN_W-1:0]);
    a_inf = (&a_q[W-2:MAN_W]) && !(|a_q[MAN_W-1:0]);
    b_inf = (&b_q[W-2:MAN_W]) && !(|b_q[MAN_W-1:0]);
    special = a_nan || b_nan || a_inf || b_inf;
    fl_sp = 4'b0000;
    if (a_nan || b_nan || (a_inf && b_inf && (a_q[W-1] != sbe))) begin
      z_sp  = {1'b0, {EXP_W{1'b1}}, 1'b1, (MAN_W-1)'(0)};
      fl_sp = 4'b0010;
    end else if (a_inf) z_sp = {a_q[W-1], {EXP_W{1'b1}}, MAN_W'(0)};
    else                z_sp = {sbe, {EXP_W{1'b1}}, MAN_W'(0)};

    // Alignment: larger magnitude first, shift the other right with sticky.
    a_big = (ea_q > eb_q) || ((ea_q == eb_q) && (ma_q >= mb_q));
    big_e = a_big ? ea_q : eb_q;
    sml_e = a_big ? eb_q : ea_q;
    big_m = a_big ? ma_q : mb_q;
    sml_m = a_big ? mb_q : ma_q;
    big_s = a_big ? sa_q : sb_q;
    sml_s = a_big ? sb_q : sa_q;
    diff  = DW'(big_e) - DW'(sml_e);
    ash   = (diff > DW'(MW - 1)) ? DW'(MW - 1) : diff;
    sml_al = (sml_m >> ash) | MW'(|(sml_m & ~({MW{1'b1}} << ash)));

    sum = (sa_q ^ sb_q) ? ({1'b0, ma_q} - {1'b0, mb_q}) : ({1'b0, ma_q} + {1'b0, mb_q});

    // Normalisation: carry-out right shift, else leading-zero left shift clamped at exponent 1.
    lz = DW'(MW);
    for (int i = 0; i < MW; i++) if (sum_q[i]) lz = DW'(MW - 1 - i);
    limit = DW'(ea_q) - DW'(1);
    nsh   = (lz < limit) ? lz : limit;
    if (sum_q[MW]) begin
      norm_m = {sum_q[MW:2], sum_q[1] | sum_q[0]};
      norm_e = ea_q + XW'(1);
    end else begin
      norm_m = sum_q[MW-1:0] << nsh;
      norm_e = ea_q - XW'(nsh);
    end

    // Round to nearest even, then encode.
    inx = |ma_q[2:0];
    rnd = {1'b0, ma_q[MW-1:3]} + (MAN_W+2)'(ma_q[2] & (ma_q[1] | ma_q[0] | ma_q[3]));
    rm  = rnd[MAN_W+1] ? rnd[MAN_W+1:1] : rnd[MAN_W:0];
    re  = rnd[MAN_W+1] ? (ea_q + XW'(1)) : ea_q;
    if (zero_q) begin
      z_rnd  = {zsign_q, (W-1)'(0)};
      fl_rnd = {1'b0, ftz_q, 1'b0, ftz_q};
    end else if (re >= XW'({EXP_W{1'b1}})) begin
      z_rnd  = {sa_q, {EXP_W{1'b1}}, MAN_W'(0)};
      fl_rnd = 4'b1001;
    end else if (!rm[MAN_W]) begin
`ifdef FP_ADDSUB_SUBNORMAL_EN
      z_rnd  = {sa_q, EXP_W'(0), rm[MAN_W-1:0]};
      fl_rnd = {1'b0, inx, 1'b0, inx};
`else
      z_rnd  = {sa_q, (W-1)'(0)};
      fl_rnd = 4'b0101;
`endif
    end else begin
      z_rnd  = {sa_q, re[EXP_W-1:0], rm[MAN_W-1:0]};
      fl_rnd = {1'b0, ftz_q, 1'b0, inx | ftz_q};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_out   = 1'b0;
    z_next     = z_rnd;
    fl_next    = fl_rnd;
    case (state)
      IDLE:   if (in_valid && in_ready) state_next = UNPACK;
      UNPACK: begin
        if (special) begin
          state_next = OUT;
          load_out   = 1'b1;
          z_next     = z_sp;
          fl_next    = fl_sp;
        end else state_next = ALIGN;
      end
      ALIGN:  state_next = ADD;
      ADD:    state_next = NORM;
      NORM:   state_next = ROUND;
      ROUND: begin
        state_next = OUT;
        load_out   = 1'b1;
      end
      OUT:     if (out_valid && out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage registers; contents are don't-care outside an operation.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: if (in_valid && in_ready) begin
        a_q   <= in_a;
        b_q   <= in_b;
        sub_q <= op_sub;
      end
      UNPACK: begin
        sa_q  <= a_q[W-1];
        sb_q  <= sbe;
        ea_q  <= ua[XW+MW-1:MW];
        ma_q  <= ua[MW-1:0];
        eb_q  <= ub[XW+MW-1:MW];
        mb_q  <= ub[MW-1:0];
        ftz_q <= ua[XW+MW] | ub[XW+MW];
      end
      ALIGN: begin
        sa_q <= big_s;
        sb_q <= sml_s;
        ea_q <= big_e;
        ma_q <= big_m;
        mb_q <= sml_al;
      end
      ADD: begin
        sum_q   <= sum;
        zsign_q <= sa_q & sb_q;
      end
      NORM: begin
        ma_q   <= norm_m;
        ea_q   <= norm_e;
        zero_q <= (sum_q == '0);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
      out_z     <= '0;
      {overflow, underflow, invalid, inexact} <= 4'b0000;
    end else begin
      out_valid <= (state == OUT) && !(out_valid && out_ready);
      in_ready  <= (state_next == IDLE);
      if (load_out) begin
        out_z <= z_next;
        {overflow, underflow, invalid, inexact} <= fl_next;
      end
    end
  end
endmodule

// File: tb/tb_fp_addsub_gen.sv
// Directed vector bench for fp_addsub_gen (EXP_W=8, MAN_W=23), plus backpressure and reset sequences.
module tb_fp_addsub_gen;
  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [31:0] in_a, in_b, out_z;
  logic        overflow, underflow, invalid, inexact;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  fp_addsub_gen #(.EXP_W(8), .MAN_W(23)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sub(op_sub),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready), .out_z(out_z),
    .overflow(overflow), .underflow(underflow), .invalid(invalid), .inexact(inexact)
  );

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [31:0] z;
    logic [3:0]  fl;   // {overflow, underflow, invalid, inexact}
    int          lat;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Issue one operation; returns the first valid result and its latency (-1 on timeout).
  task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic sub,
                        output logic [31:0] z, output logic [3:0] fl, output int lat);
    @(negedge clk);
    in_a = a; in_b = b; op_sub = sub; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    z  = out_z;
    fl = {overflow, underflow, invalid, inexact};
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] z;
    logic [3:0]  fl;
    int          lat;
    logic        seen;

    vecs[0]  = '{32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 4'b0000, 6};
    vecs[1]  = '{32'h3F800000, 32'h3F800000, 1'b1, 32'h00000000, 4'b0000, 6};
    vecs[2]  = '{32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b1001, 6};
    vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b0010, 2};
    vecs[4]  = '{32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 6};
    vecs[5]  = '{32'h7F800001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0010, 2};
    vecs[6]  = '{32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 4'b0000, 2};
    vecs[7]  = '{32'h3F800000, 32'hFF800000, 1'b0, 32'hFF800000, 4'b0000, 2};
    vecs[8]  = '{32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 6};
    vecs[9]  = '{32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 6};
    vecs[10] = '{32'h3F800000, 32'h0D800000, 1'b0, 32'h3F800000, 4'b0001, 6};
    vecs[11] = '{32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 6};
    vecs[12] = '{32'h80000000, 32'h00000000, 1'b0, 32'h00000000, 4'b0000, 6};
    vecs[13] = '{32'h3FFFFFFF, 32'h33800000, 1'b0, 32'h40000000, 4'b0001, 6};
    vecs[14] = '{32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4'b0000, 6};
    vecs[15] = '{32'h7F800000, 32'hFF800000, 1'b1, 32'h7F800000, 4'b0000, 2};

    rst = 1'b1; in_valid = 1'b0; op_sub = 1'b0; in_a = '0; in_b = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd1);
    check("reset out_z", 64'(out_z), 64'd0);
    check("reset flags", 64'({overflow, underflow, invalid, inexact}), 64'd0);
    @(negedge clk) rst = 1'b0;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].sub, z, fl, lat);
      check($sformatf("vec%0d z", i), 64'(z), 64'(vecs[i].z));
      check($sformatf("vec%0d flags", i), 64'(fl), 64'(vecs[i].fl));
      check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].lat));
    end

    // Smallest subnormal doubled: gradual underflow vs flush-to-zero.
    run_op(32'h00000001, 32'h00000001, 1'b0, z, fl, lat);
`ifdef FP_ADDSUB_SUBNORMAL_EN
    check("subnormal z", 64'(z), 64'h00000002);
    check("subnormal underflow", 64'(fl[2]), 64'd0);
`else
    check("subnormal z", 64'(z), 64'h00000000);
    check("subnormal underflow", 64'(fl[2]), 64'd1);
`endif
    check("subnormal latency", 64'(lat), 64'd6);

    // Backpressure: result and flags held while out_ready is low.
    @(negedge clk) out_ready = 1'b0;
    run_op(32'h40000000, 32'h40000000, 1'b0, z, fl, lat);
    check("bp z", 64'(z), 64'h40800000);
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check($sformatf("bp hold%0d valid", k), 64'(out_valid), 64'd1);
      check($sformatf("bp hold%0d z", k), 64'(out_z), 64'h40800000);
      check($sformatf("bp hold%0d in_ready", k), 64'(in_ready), 64'd0);
    end
    @(negedge clk) out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp release valid", 64'(out_valid), 64'd0);
    check("bp release in_ready", 64'(in_ready), 64'd1);

    // Reset pulse while the operation sits in ALIGN.
    @(negedge clk);
    in_a = 32'h3F800000; in_b = 32'h40000000; op_sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    #1;
    check("rst in_ready", 64'(in_ready), 64'd1);
    check("rst out_valid", 64'(out_valid), 64'd0);
    @(negedge clk) rst = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check("rst abandoned op", 64'(seen), 64'd0);

    run_op(32'h3F800000, 32'h40000000, 1'b0, z, fl, lat);
    check("post-rst z", 64'(z), 64'h40400000);
    check("post-rst latency", 64'(lat), 64'd6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
